// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the uart_tx byte input.
// Valid/ready: a byte moves on a cycle where valid and ready are both high; the
// producer keeps data/last stable while valid is high and ready is low.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 pause;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    modport master (
        output req_data, req_valid, req_last, pause, out_ready,
        input  req_ready, out_data, out_valid, grant_id, busy
    );

    modport slave (
        input  req_data, req_valid, req_last, pause, out_ready,
        output req_ready, out_data, out_valid, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that merges NUM_REQ byte streams onto one
// registered uart_tx byte handshake, with optional per-grant burst limit.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus,
    output logic              state_dbg
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BW-1:0] BURST_END = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e         state;
    logic [IDW-1:0] g;
    logic [IDW-1:0] last;
    logic [BW-1:0]  beat_cnt;
    logic [7:0]     out_data_q;
    logic           out_valid_q;

    logic           can_load;
    logic           grant_open;
    logic           hs;
    logic           burst_hit;
    logic           release_now;
    logic [7:0]     sel_data;
    logic           sel_valid;
    logic           sel_last;
    logic           hi_found;
    logic           lo_found;
    logic [IDW-1:0] hi_id;
    logic [IDW-1:0] lo_id;
    logic           win_found;
    logic [IDW-1:0] win_id;

    // Round robin: lowest valid index above 'last' wins, otherwise wrap to the lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (IDW'(i) > last) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_id    = IDW'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_id    = IDW'(i);
                end
            end
        end
        win_found = hi_found || lo_found;
        win_id    = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g == IDW'(i)) begin
                sel_data  = bus.req_data[8*i +: 8];
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
            end
        end
    end

    assign can_load    = !out_valid_q || bus.out_ready;
    assign grant_open  = (state == S_GRANT) && !bus.pause && can_load;
    assign hs          = grant_open && sel_valid;
    assign burst_hit   = (MAX_BURST != 0) && (beat_cnt == BURST_END);
    assign release_now = hs && (sel_last || burst_hit);

    // Ready goes only to the holder of the grant; it never depends on req_* inputs.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = grant_open && (g == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            g           <= '0;
            last        <= IDW'(NUM_REQ - 1);
            beat_cnt    <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.pause && win_found) begin
                        g        <= win_id;
                        beat_cnt <= '0;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (release_now) begin
                        last  <= g;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (hs) begin
                out_data_q  <= sel_data;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.grant_id  = g;
    assign bus.busy      = (state == S_GRANT) || out_valid_q;
    assign state_dbg     = (state == S_GRANT);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a packet-level
// round-robin model that predicts grant order and the merged byte stream.
module tb_uart_tx_arbiter;
  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic state_dbg;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] rq_mem [NR][DEPTH];
  int         rq_head [NR];
  int         rq_tail [NR];
  logic [7:0] exp_q[$];
  int         exp_g[$];
  int         grant_log[$];
  int         gap_log[$];
  int         model_last;
  bit         rnd_mode;
  bit         prev_stall;
  logic [7:0] prev_data;
  bit         prev_st;
  int         idle_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive();
    logic [NR*8-1:0] d;
    logic [NR-1:0]   v;
    logic [NR-1:0]   l;
    d = '0;
    v = '0;
    l = '0;
    for (int i = 0; i < NR; i++) begin
      if (rq_head[i] < rq_tail[i]) begin
        v[i]       = 1'b1;
        d[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
        l[i]       = rq_mem[i][rq_head[i]][8];
      end
    end
    bus.req_data  = d;
    bus.req_valid = v;
    bus.req_last  = l;
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input logic l);
    rq_mem[r][rq_tail[r]] = {l, b};
    rq_tail[r]++;
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(r, 8'($urandom_range(0, 255)), k == len - 1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    exp_q.delete();
    exp_g.delete();
    grant_log.delete();
    gap_log.delete();
    prev_stall = 1'b0;
    prev_st    = 1'b0;
    idle_run   = 0;
    model_last = NR - 1;
    drive();
  endtask

  task automatic clear_logs();
    exp_g.delete();
    grant_log.delete();
    gap_log.delete();
    for (int i = 0; i < NR; i++) begin
      if (rq_head[i] == rq_tail[i]) begin
        rq_head[i] = 0;
        rq_tail[i] = 0;
      end
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_all();
    #2;
    rst_n = 1'b1;
  endtask

  // Packet-level model: each grant goes to the next pending requester after the
  // previous holder and lasts until a last byte, MB bytes, or its data runs out.
  task automatic build_model();
    int h[NR];
    int sel;
    int idx;
    int n;
    bit any;
    logic [8:0] e;
    for (int i = 0; i < NR; i++) h[i] = rq_head[i];
    do begin
      any = 1'b0;
      sel = 0;
      for (int off = 1; off <= NR; off++) begin
        idx = (model_last + off) % NR;
        if (!any && h[idx] < rq_tail[idx]) begin
          any = 1'b1;
          sel = idx;
        end
      end
      if (any) begin
        exp_g.push_back(sel);
        n = 0;
        do begin
          e = rq_mem[sel][h[sel]];
          h[sel]++;
          exp_q.push_back(e[7:0]);
          n++;
        end while (!e[8] && n != MB && h[sel] < rq_tail[sel]);
        model_last = sel;
      end
    end while (any);
  endtask

  // One clock: sample what the coming edge will see, then drive the next inputs.
  task automatic cycle();
    #1;
    if (state_dbg && !prev_st) begin
      grant_log.push_back(int'(bus.grant_id));
      gap_log.push_back(idle_run);
      idle_run = 0;
    end else if (!state_dbg) begin
      idle_run++;
    end
    prev_st = state_dbg;
    check("ready_onehot", $countones(bus.req_ready) <= 1, 1);
    if (prev_stall) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, prev_data);
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    if (bus.out_valid && bus.out_ready) begin
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sb_data", bus.out_data, exp_q.pop_front());
    end
    for (int i = 0; i < NR; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        check("hs_grant", bus.grant_id, i);
        rq_head[i]++;
      end
    end
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.pause     = ($urandom_range(0, 7) == 0);
    end
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      cycle();
      n++;
      done = (exp_q.size() == 0) && !bus.out_valid;
    end
    check("drain", done, 1);
  endtask

  task automatic cmp_grants();
    int m;
    check("grant_count", grant_log.size(), exp_g.size());
    m = (grant_log.size() < exp_g.size()) ? grant_log.size() : exp_g.size();
    for (int k = 0; k < m; k++) check("grant_order", grant_log[k], exp_g[k]);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    bus.pause     = 1'b0;
    rnd_mode      = 1'b0;
    clear_all();
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", state_dbg, 0);
    #2;
    rst_n = 1'b1;

    // single requester, three-byte packet
    push_byte(1, 8'h41, 1'b0);
    push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b1);
    build_model();
    drive();
    cycle();
    check("t1_state_c1", state_dbg, 1);
    check("t1_grant_id", bus.grant_id, 1);
    #1;
    check("t1_ready_c1", bus.req_ready, 4'b0010);
    cycle();
    check("t1_valid_c2", bus.out_valid, 1);
    check("t1_data_c2", bus.out_data, 8'h41);
    cycle();
    check("t1_data_c3", bus.out_data, 8'h42);
    cycle();
    check("t1_data_c4", bus.out_data, 8'h43);
    check("t1_idle_c4", state_dbg, 0);
    cycle();
    check("t1_drained", bus.out_valid, 0);
    check("t1_busy", bus.busy, 0);
    cmp_grants();

    // all requesters with single-byte packets, twice each
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push_byte(i, 8'(16 * i + r), 1'b1);
    build_model();
    drive();
    run_until_done(200);
    cmp_grants();
    for (int k = 1; k < gap_log.size(); k++) check("rearb_gap", gap_log[k], 1);

    // burst limit forces release of a long stream
    reset_dut();
    for (int k = 0; k < 10; k++) push_byte(2, 8'(8'h20 + k), 1'b0);
    push_byte(3, 8'h3c, 1'b1);
    build_model();
    drive();
    run_until_done(300);
    cmp_grants();
    check("t3_lock_state", state_dbg, 1);
    check("t3_lock_grant", bus.grant_id, 2);

    // output stall with 0x55 presented
    reset_dut();
    bus.out_ready = 1'b0;
    push_byte(0, 8'h55, 1'b0);
    push_byte(0, 8'h56, 1'b1);
    build_model();
    drive();
    cycle();
    cycle();
    check("t4_valid", bus.out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("t4_hold_data", bus.out_data, 8'h55);
      check("t4_hold_valid", bus.out_valid, 1);
      check("t4_hold_ready", bus.req_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4_ready_on", bus.req_ready, 4'b0001);
    cycle();
    check("t4_next_data", bus.out_data, 8'h56);
    check("t4_next_valid", bus.out_valid, 1);
    run_until_done(50);

    // pause mid-packet
    reset_dut();
    push_pkt(0, 5);
    push_pkt(1, 2);
    build_model();
    drive();
    cycle();
    cycle();
    cycle();
    bus.pause = 1'b1;
    #1;
    check("t5_pause_ready", bus.req_ready, 0);
    cycle();
    check("t5_drained", bus.out_valid, 0);
    check("t5_hold_state", state_dbg, 1);
    check("t5_hold_grant", bus.grant_id, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t5_paused_ready", bus.req_ready, 0);
      check("t5_paused_valid", bus.out_valid, 0);
    end
    bus.pause = 1'b0;
    run_until_done(100);
    cmp_grants();

    // asynchronous reset while a byte is held
    reset_dut();
    push_pkt(3, 4);
    build_model();
    drive();
    cycle();
    cycle();
    check("t6_pre_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.out_valid, 0);
    check("t6_async_ready", bus.req_ready, 0);
    check("t6_async_busy", bus.busy, 0);
    check("t6_async_state", state_dbg, 0);
    clear_all();
    rst_n = 1'b1;
    push_pkt(3, 2);
    push_pkt(2, 1);
    push_pkt(0, 3);
    build_model();
    drive();
    run_until_done(100);
    cmp_grants();
    if (grant_log.size() > 0) check("t6_first_grant", grant_log[0], 0);

    // randomized traffic with random back-pressure and pause
    for (int round = 0; round < 6; round++) begin
      clear_logs();
      for (int i = 0; i < NR; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) push_pkt(i, $urandom_range(1, 7));
      end
      if (rq_head[0] == rq_tail[0]) push_pkt(0, 2);
      build_model();
      rnd_mode = 1'b1;
      drive();
      run_until_done(3000);
      rnd_mode = 1'b0;
      bus.pause = 1'b0;
      bus.out_ready = 1'b1;
      cycle();
      check("rnd_idle", state_dbg, 0);
      cmp_grants();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
